speicher_schnittstelle: RTL and testbench

Single-port memory interface between the CPU core and the shared instruction/data memory. It accepts the CPU's instruction-fetch request and its data load/store requests. It serialises them onto one memory port with a variable-latency ready handshake, and it returns completion pulses (`InstruktionGeladen`, `DatenGeladen`, `DatenGespeichert`) that the CPU controller waits on. A per-access timeout guarantees the CPU never hangs on an unresponsive memory.

---
 rtl/speicher_schnittstelle.sv | 136 +++++++++++++
 tb/tb_speicher_schnittstelle.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/speicher_schnittstelle.sv
// Single-port memory interface: serialises CPU fetch, load and store requests
// onto one memory port and returns one-cycle completion pulses to the CPU.
module speicher_schnittstelle #(
  parameter int ADRESS_BREITE = 26,
  parameter int TIMEOUT       = 255
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [31:0]              InstruktionAdresse,
  input  logic                     LeseInstruktion,
  output logic [31:0]              Instruktion,
  output logic                     InstruktionGeladen,
  input  logic [31:0]              DatenAdresse,
  input  logic [31:0]              DatenVonCPU,
  input  logic                     LeseDaten,
  input  logic                     SchreibeDaten,
  output logic [31:0]              DatenRein,
  output logic                     DatenGeladen,
  output logic                     DatenGespeichert,
  output logic [ADRESS_BREITE-1:0] SpeicherAdresse,
  output logic [31:0]              SpeicherDatenRaus,
  output logic                     SpeicherSchreiben,
  output logic                     SpeicherAnfrage,
  input  logic [31:0]              SpeicherDatenRein,
  input  logic                     SpeicherBereit,
  output logic                     Fehler
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INSTR     = 3'd1,
    LESEN     = 3'd2,
    SCHREIBEN = 3'd3,
    FERTIG    = 3'd4
  } zustand_t;

  localparam logic [7:0] TIMEOUT_GRENZE = 8'(TIMEOUT);
  localparam bit         TIMEOUT_AKTIV  = (TIMEOUT != 0);

  zustand_t    zustand;
  logic [7:0]  zaehler;
  logic        beschaeftigt;
  logic        abschluss;
  logic        abbruch;
  logic [31:0] lese_wert;

  // Only the low address bits are forwarded to the memory.
  logic unused_adress_bits;
  assign unused_adress_bits = ^{InstruktionAdresse, DatenAdresse};

  // Memory handshake: SpeicherAnfrage is held with stable address/data/type
  // until a cycle with SpeicherBereit=1; Bereit is ignored while Anfrage=0.
  always_comb begin
    beschaeftigt = (zustand == INSTR) || (zustand == LESEN) || (zustand == SCHREIBEN);
    abbruch      = 1'b0;
    abschluss    = 1'b0;
    lese_wert    = SpeicherDatenRein;
    if (beschaeftigt) begin
      if (SpeicherBereit) begin
        abschluss = 1'b1;
      end else if (TIMEOUT_AKTIV && (zaehler == TIMEOUT_GRENZE)) begin
        abschluss = 1'b1;
        abbruch   = 1'b1;
        lese_wert = 32'h0000_0000;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand            <= IDLE;
      zaehler            <= 8'd0;
      SpeicherAnfrage    <= 1'b0;
      SpeicherSchreiben  <= 1'b0;
      SpeicherAdresse    <= '0;
      SpeicherDatenRaus  <= 32'h0;
      Instruktion        <= 32'h0;
      DatenRein          <= 32'h0;
      InstruktionGeladen <= 1'b0;
      DatenGeladen       <= 1'b0;
      DatenGespeichert   <= 1'b0;
      Fehler             <= 1'b0;
    end else begin
      InstruktionGeladen <= 1'b0;
      DatenGeladen       <= 1'b0;
      DatenGespeichert   <= 1'b0;
      case (zustand)
        IDLE: begin
          zaehler <= 8'd0;
          if (SchreibeDaten) begin
            zustand           <= SCHREIBEN;
            SpeicherAnfrage   <= 1'b1;
            SpeicherSchreiben <= 1'b1;
            SpeicherAdresse   <= DatenAdresse[ADRESS_BREITE-1:0];
            SpeicherDatenRaus <= DatenVonCPU;
            // Load and store together is a CPU protocol error; the store wins.
            if (LeseDaten) Fehler <= 1'b1;
          end else if (LeseDaten) begin
            zustand           <= LESEN;
            SpeicherAnfrage   <= 1'b1;
            SpeicherSchreiben <= 1'b0;
            SpeicherAdresse   <= DatenAdresse[ADRESS_BREITE-1:0];
          end else if (LeseInstruktion) begin
            zustand           <= INSTR;
            SpeicherAnfrage   <= 1'b1;
            SpeicherSchreiben <= 1'b0;
            SpeicherAdresse   <= InstruktionAdresse[ADRESS_BREITE-1:0];
          end
        end
        INSTR, LESEN, SCHREIBEN: begin
          if (abschluss) begin
            zustand         <= FERTIG;
            SpeicherAnfrage <= 1'b0;
            if (abbruch) Fehler <= 1'b1;
            case (zustand)
              INSTR: begin
                Instruktion        <= lese_wert;
                InstruktionGeladen <= 1'b1;
              end
              LESEN: begin
                DatenRein    <= lese_wert;
                DatenGeladen <= 1'b1;
              end
              default: DatenGespeichert <= 1'b1;
            endcase
          end else begin
            zaehler <= zaehler + 8'd1;
          end
        end
        FERTIG:  zustand <= IDLE;
        default: zustand <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_speicher_schnittstelle.sv
// Directed bench for speicher_schnittstelle: table of single accesses against a
// wait-state memory model, plus hand sequences for priority, reset and errors.
module tb_speicher_schnittstelle;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] InstruktionAdresse;
  logic        LeseInstruktion;
  logic [31:0] Instruktion;
  logic        InstruktionGeladen;
  logic [31:0] DatenAdresse;
  logic [31:0] DatenVonCPU;
  logic        LeseDaten;
  logic        SchreibeDaten;
  logic [31:0] DatenRein;
  logic        DatenGeladen;
  logic        DatenGespeichert;
  logic [25:0] SpeicherAdresse;
  logic [31:0] SpeicherDatenRaus;
  logic        SpeicherSchreiben;
  logic        SpeicherAnfrage;
  logic [31:0] SpeicherDatenRein;
  logic        SpeicherBereit;
  logic        Fehler;

  speicher_schnittstelle #(.ADRESS_BREITE(26), .TIMEOUT(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .InstruktionAdresse(InstruktionAdresse), .LeseInstruktion(LeseInstruktion),
    .Instruktion(Instruktion), .InstruktionGeladen(InstruktionGeladen),
    .DatenAdresse(DatenAdresse), .DatenVonCPU(DatenVonCPU),
    .LeseDaten(LeseDaten), .SchreibeDaten(SchreibeDaten),
    .DatenRein(DatenRein), .DatenGeladen(DatenGeladen), .DatenGespeichert(DatenGespeichert),
    .SpeicherAdresse(SpeicherAdresse), .SpeicherDatenRaus(SpeicherDatenRaus),
    .SpeicherSchreiben(SpeicherSchreiben), .SpeicherAnfrage(SpeicherAnfrage),
    .SpeicherDatenRein(SpeicherDatenRein), .SpeicherBereit(SpeicherBereit),
    .Fehler(Fehler)
  );

  // Clock and reset
  always #5 Clock = ~Clock;

  typedef struct {
    int          kind;       // 0 fetch, 1 load, 2 store, 3 load+store
    logic [31:0] adr;
    logic [31:0] exp_adr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    int          exp_lat;
    int          exp_anf;
    logic [31:0] exp_instr;
    logic [31:0] exp_daten;
    logic        exp_fehler;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          mem_waits;
  int          mem_cnt;
  logic [31:0] mem_rdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock step; the memory model answers after a fixed number of wait cycles.
  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
    if (SpeicherAnfrage) begin
      mem_cnt++;
      SpeicherBereit    = (mem_cnt > mem_waits);
      SpeicherDatenRein = mem_rdata;
    end else begin
      mem_cnt           = 0;
      SpeicherBereit    = 1'b0;
      SpeicherDatenRein = 32'hDEAD_0000;
    end
  endtask

  task automatic clear_requests();
    LeseInstruktion = 1'b0;
    LeseDaten       = 1'b0;
    SchreibeDaten   = 1'b0;
  endtask

  // Driver: issues one access from IDLE and checks it to the single completion pulse.
  task automatic run_access(input vec_t v, input string name);
    logic [2:0] exp_pulse;
    logic       schreib;
    int         anf;
    bit         got;
    exp_pulse = (v.kind == 0) ? 3'b100 : (v.kind == 1) ? 3'b010 : 3'b001;
    schreib   = (v.kind >= 2);
    mem_waits = v.waits;
    mem_rdata = v.rdata;
    InstruktionAdresse = v.adr;
    DatenAdresse       = v.adr;
    DatenVonCPU        = v.wdata;
    LeseInstruktion    = (v.kind == 0);
    LeseDaten          = (v.kind == 1) || (v.kind == 3);
    SchreibeDaten      = (v.kind >= 2);
    cyc = 0;
    anf = 0;
    got = 0;
    while (!got && cyc < 40) begin
      tick();
      if (cyc == 1) begin
        InstruktionAdresse = $urandom;
        DatenAdresse       = $urandom;
        DatenVonCPU        = $urandom;
      end
      if (SpeicherAnfrage) begin
        anf++;
        check({name, " adr"}, 32'(SpeicherAdresse), v.exp_adr);
        check({name, " schreiben"}, 32'(SpeicherSchreiben), 32'(schreib));
        if (schreib) check({name, " datenraus"}, SpeicherDatenRaus, v.wdata);
      end
      if (InstruktionGeladen || DatenGeladen || DatenGespeichert) begin
        got = 1;
        clear_requests();
        check({name, " pulse"}, 32'({InstruktionGeladen, DatenGeladen, DatenGespeichert}), 32'(exp_pulse));
        check({name, " latency"}, 32'(cyc), 32'(v.exp_lat));
        check({name, " anfrage_cycles"}, 32'(anf), 32'(v.exp_anf));
        check({name, " anfrage_low"}, 32'(SpeicherAnfrage), 32'd0);
        check({name, " instruktion"}, Instruktion, v.exp_instr);
        check({name, " datenrein"}, DatenRein, v.exp_daten);
        check({name, " fehler"}, 32'(Fehler), 32'(v.exp_fehler));
      end
    end
    if (!got) begin
      errors++;
      $display("FAIL %s: no completion pulse within 40 cycles", name);
      clear_requests();
    end
    tick();
    check({name, " single_pulse"}, 32'({InstruktionGeladen, DatenGeladen, DatenGespeichert}), 32'd0);
  endtask

  vec_t tab [9];

  initial begin : main
    vec_t v;
    int   t_dg;
    int   t_ig;
    int   stray;
    // kind adr exp_adr wdata rdata waits lat anf instr daten fehler
    tab[0] = '{0, 32'h0000_0010, 32'h10, 32'h0, 32'h1234_5678, 0, 2, 1, 32'h1234_5678, 32'h0, 1'b0};
    tab[1] = '{2, 32'h0000_0040, 32'h40, 32'hCAFE_BABE, 32'h0, 3, 5, 4, 32'h1234_5678, 32'h0, 1'b0};
    tab[2] = '{1, 32'h0000_1234, 32'h1234, 32'h0, 32'hDEAD_BEEF, 1, 3, 2, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0};
    tab[3] = '{0, 32'hFFFF_FFFC, 32'h03FF_FFFC, 32'h0, 32'hA5A5_A5A5, 2, 4, 3, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1'b0};
    tab[4] = '{1, 32'h0000_0088, 32'h88, 32'h0, 32'h0BAD_F00D, 3, 5, 4, 32'hA5A5_A5A5, 32'h0BAD_F00D, 1'b0};
    tab[5] = '{1, 32'h0000_0080, 32'h80, 32'h0, 32'h7777_7777, 99, 6, 5, 32'hA5A5_A5A5, 32'h0, 1'b1};
    tab[6] = '{0, 32'h0000_0020, 32'h20, 32'h0, 32'h1111_2222, 0, 2, 1, 32'h1111_2222, 32'h0, 1'b1};
    tab[7] = '{0, 32'h0000_0030, 32'h30, 32'h0, 32'h3333_3333, 99, 6, 5, 32'h0, 32'h0, 1'b1};
    tab[8] = '{2, 32'h0000_0034, 32'h34, 32'h1357_9BDF, 32'h0, 99, 6, 5, 32'h0, 32'h0, 1'b1};

    Reset = 1'b1;
    clear_requests();
    InstruktionAdresse = 32'h0;
    DatenAdresse       = 32'h0;
    DatenVonCPU        = 32'h0;
    SpeicherDatenRein  = 32'h0;
    SpeicherBereit     = 1'b0;
    mem_waits = 0;
    mem_rdata = 32'h0;
    mem_cnt   = 0;
    cyc       = 0;
    repeat (3) tick();
    check("reset anfrage", 32'(SpeicherAnfrage), 32'd0);
    check("reset schreiben", 32'(SpeicherSchreiben), 32'd0);
    check("reset adr", 32'(SpeicherAdresse), 32'd0);
    check("reset datenraus", SpeicherDatenRaus, 32'd0);
    check("reset instruktion", Instruktion, 32'd0);
    check("reset datenrein", DatenRein, 32'd0);
    check("reset pulses", 32'({InstruktionGeladen, DatenGeladen, DatenGespeichert}), 32'd0);
    check("reset fehler", 32'(Fehler), 32'd0);
    Reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_access(tab[i], $sformatf("vec%0d", i));
    end

    // Load and fetch rise together: load first, fetch in the next IDLE cycle.
    mem_waits = 0;
    mem_rdata = 32'h7777_8888;
    InstruktionAdresse = 32'h50;
    DatenAdresse       = 32'h54;
    LeseInstruktion    = 1'b1;
    LeseDaten          = 1'b1;
    cyc  = 0;
    t_dg = -1;
    t_ig = -1;
    while (t_ig < 0 && cyc < 30) begin
      tick();
      if (cyc == 1) check("simul load adr", 32'(SpeicherAdresse), 32'h54);
      if (cyc == 4) check("simul fetch adr", 32'(SpeicherAdresse), 32'h50);
      if (DatenGeladen && t_dg < 0) begin
        t_dg = cyc;
        LeseDaten = 1'b0;
        mem_rdata = 32'h9999_AAAA;
      end
      if (InstruktionGeladen) begin
        t_ig = cyc;
        LeseInstruktion = 1'b0;
      end
    end
    clear_requests();
    check("simul dg time", 32'(t_dg), 32'd2);
    check("simul ig time", 32'(t_ig), 32'd5);
    check("simul datenrein", DatenRein, 32'h7777_8888);
    check("simul instruktion", Instruktion, 32'h9999_AAAA);
    tick();

    // Reset during the second wait cycle of a load.
    mem_waits    = 99;
    DatenAdresse = 32'h60;
    LeseDaten    = 1'b1;
    cyc = 0;
    tick();
    tick();
    check("rst mid anfrage_before", 32'(SpeicherAnfrage), 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    LeseDaten = 1'b0;
    check("rst mid anfrage", 32'(SpeicherAnfrage), 32'd0);
    check("rst mid datengeladen", 32'(DatenGeladen), 32'd0);
    check("rst mid datenrein", DatenRein, 32'd0);
    check("rst mid fehler", 32'(Fehler), 32'd0);
    stray = 0;
    repeat (8) begin
      tick();
      if (DatenGeladen || SpeicherAnfrage) stray++;
    end
    check("rst mid quiet", 32'(stray), 32'd0);

    v = '{0, 32'h0000_0070, 32'h70, 32'h0, 32'h3C3C_3C3C, 1, 3, 2, 32'h3C3C_3C3C, 32'h0, 1'b0};
    run_access(v, "post_reset_fetch");
    v = '{3, 32'h0000_0044, 32'h44, 32'h55AA_55AA, 32'h0, 0, 2, 1, 32'h3C3C_3C3C, 32'h0, 1'b1};
    run_access(v, "illegal_ld_st");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
